// File: rtl/reorder_buffer_pkg.sv
// Shared ROB definitions: geometry constants and the per-entry control record.
// Register file and reservation stations size their tag fields from these constants.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH  = 8;
  localparam int ROB_IDX_W  = $clog2(ROB_DEPTH);
  localparam int ROB_DATA_W = 32;

  typedef struct packed {
    logic       valid;
    logic       done;
    logic       mispredict;
    logic [4:0] rd;
  } rob_entry_t;

  // x0 is hardwired to zero, so a retire into it must not write the register file
  function automatic logic rd_writes(input logic [4:0] rd);
    return rd != 5'd0;
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue/CDB/forwarding/retire bundle of the reorder buffer.
// The master is the core side (issue, CDB, register file); the slave is the ROB.
interface reorder_buffer_if import reorder_buffer_pkg::*; #(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int IDX_W  = ROB_IDX_W,
  parameter int DATA_W = ROB_DATA_W
);

  logic              alloc_valid_in;
  logic [4:0]        alloc_rd_in;
  logic              alloc_ready_out;
  logic [IDX_W-1:0]  alloc_idx_out;

  logic              cdb_valid_in;
  logic [IDX_W-1:0]  cdb_rob_idx_in;
  logic [DATA_W-1:0] cdb_data_in;
  logic              cdb_mispredict_in;

  logic [IDX_W-1:0]  src1_idx_in;
  logic [IDX_W-1:0]  src2_idx_in;
  logic              src1_ready_out;
  logic              src2_ready_out;
  logic [DATA_W-1:0] src1_data_out;
  logic [DATA_W-1:0] src2_data_out;

  logic              commit_valid_out;
  logic              commit_we_out;
  logic [4:0]        commit_wa_out;
  logic [DATA_W-1:0] commit_wd_out;
  logic [IDX_W-1:0]  commit_rob_idx_out;
  logic              flush_out;
  logic [DEPTH-1:0]  flush_mask_out;
  logic [IDX_W:0]    count_out;

  modport master (
    output alloc_valid_in, alloc_rd_in,
    input  alloc_ready_out, alloc_idx_out,
    output cdb_valid_in, cdb_rob_idx_in, cdb_data_in, cdb_mispredict_in,
    output src1_idx_in, src2_idx_in,
    input  src1_ready_out, src2_ready_out, src1_data_out, src2_data_out,
    input  commit_valid_out, commit_we_out, commit_wa_out, commit_wd_out, commit_rob_idx_out,
    input  flush_out, flush_mask_out, count_out
  );

  modport slave (
    input  alloc_valid_in, alloc_rd_in,
    output alloc_ready_out, alloc_idx_out,
    input  cdb_valid_in, cdb_rob_idx_in, cdb_data_in, cdb_mispredict_in,
    input  src1_idx_in, src2_idx_in,
    output src1_ready_out, src2_ready_out, src1_data_out, src2_data_out,
    output commit_valid_out, commit_we_out, commit_wa_out, commit_wd_out, commit_rob_idx_out,
    output flush_out, flush_mask_out, count_out
  );

endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: tags issued instructions, captures CDB results,
// forwards operands, retires one entry per cycle in order and flushes on mispredict.
module reorder_buffer import reorder_buffer_pkg::*; #(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int IDX_W  = ROB_IDX_W,
  parameter int DATA_W = ROB_DATA_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  reorder_buffer_if.slave  rob
);

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

  rob_entry_t        r_ent  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [IDX_W:0]    r_head, r_tail;
  logic              r_cmt_valid, r_cmt_we, r_flush;
  logic [4:0]        r_cmt_wa;
  logic [DATA_W-1:0] r_cmt_wd;
  logic [IDX_W-1:0]  r_cmt_idx;
  logic [DEPTH-1:0]  r_flush_mask;

  logic [IDX_W-1:0]  w_head_idx, w_tail_idx;
  logic [IDX_W:0]    w_count, w_tail_nxt;
  logic              w_alloc_ready, w_alloc, w_cdb_wr, w_commit, w_flush;
  logic [DEPTH-1:0]  w_mask;

  assign w_head_idx    = r_head[IDX_W-1:0];
  assign w_tail_idx    = r_tail[IDX_W-1:0];
  assign w_count       = r_tail - r_head;
  assign w_alloc_ready = (w_count < FULL_CNT) && !r_flush;
  assign w_alloc       = rob.alloc_valid_in && w_alloc_ready;
  assign w_cdb_wr      = rob.cdb_valid_in && !r_flush && r_ent[rob.cdb_rob_idx_in].valid;
  assign w_commit      = r_ent[w_head_idx].valid && r_ent[w_head_idx].done;
  assign w_flush       = w_commit && r_ent[w_head_idx].mispredict;
  assign w_tail_nxt    = r_tail + {{IDX_W{1'b0}}, w_alloc};

  // Everything younger than the mispredicted head, including a tag handed out on this very edge
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (r_ent[i].valid && (IDX_W'(i) != w_head_idx)) w_mask[i] = 1'b1;
    if (w_alloc) w_mask[w_tail_idx] = 1'b1;
  end

  always_comb begin
    rob.src1_ready_out = 1'b0;
    rob.src1_data_out  = '0;
    rob.src2_ready_out = 1'b0;
    rob.src2_data_out  = '0;
    if (r_ent[rob.src1_idx_in].valid) begin
      if (w_cdb_wr && rob.cdb_rob_idx_in == rob.src1_idx_in) begin
        rob.src1_ready_out = 1'b1;
        rob.src1_data_out  = rob.cdb_data_in;
      end else begin
        rob.src1_ready_out = r_ent[rob.src1_idx_in].done;
        rob.src1_data_out  = r_data[rob.src1_idx_in];
      end
    end
    if (r_ent[rob.src2_idx_in].valid) begin
      if (w_cdb_wr && rob.cdb_rob_idx_in == rob.src2_idx_in) begin
        rob.src2_ready_out = 1'b1;
        rob.src2_data_out  = rob.cdb_data_in;
      end else begin
        rob.src2_ready_out = r_ent[rob.src2_idx_in].done;
        rob.src2_data_out  = r_data[rob.src2_idx_in];
      end
    end
  end

  // Entry state and pointers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_head <= '0;
      r_tail <= '0;
    end else if (w_flush) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_head <= w_tail_nxt;
      r_tail <= w_tail_nxt;
    end else begin
      if (w_cdb_wr) begin
        r_ent[rob.cdb_rob_idx_in].done       <= 1'b1;
        r_ent[rob.cdb_rob_idx_in].mispredict <= rob.cdb_mispredict_in;
      end
      if (w_commit) r_ent[w_head_idx] <= '0;
      if (w_alloc)
        r_ent[w_tail_idx] <= '{valid: 1'b1, done: 1'b0, mispredict: 1'b0, rd: rob.alloc_rd_in};
      r_head <= r_head + {{IDX_W{1'b0}}, w_commit};
      r_tail <= w_tail_nxt;
    end
  end

  // Result payload needs no reset: it is only observed through a valid entry
  always_ff @(posedge clk_in) begin
    if (w_cdb_wr) r_data[rob.cdb_rob_idx_in] <= rob.cdb_data_in;
    if (w_alloc)  r_data[w_tail_idx] <= '0;
  end

  // Retire / flush output stage
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cmt_valid  <= 1'b0;
      r_cmt_we     <= 1'b0;
      r_cmt_wa     <= '0;
      r_cmt_wd     <= '0;
      r_cmt_idx    <= '0;
      r_flush      <= 1'b0;
      r_flush_mask <= '0;
    end else begin
      r_cmt_valid  <= w_commit;
      r_cmt_we     <= w_commit && rd_writes(r_ent[w_head_idx].rd);
      r_cmt_wa     <= w_commit ? r_ent[w_head_idx].rd : 5'd0;
      r_cmt_wd     <= w_commit ? r_data[w_head_idx] : '0;
      r_cmt_idx    <= w_commit ? w_head_idx : '0;
      r_flush      <= w_flush;
      r_flush_mask <= w_flush ? w_mask : '0;
    end
  end

  assign rob.alloc_ready_out    = w_alloc_ready;
  assign rob.alloc_idx_out      = w_tail_idx;
  assign rob.commit_valid_out   = r_cmt_valid;
  assign rob.commit_we_out      = r_cmt_we;
  assign rob.commit_wa_out      = r_cmt_wa;
  assign rob.commit_wd_out      = r_cmt_wd;
  assign rob.commit_rob_idx_out = r_cmt_idx;
  assign rob.flush_out          = r_flush;
  assign rob.flush_mask_out     = r_flush_mask;
  assign rob.count_out          = w_count;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected retirements are queued as results are
// broadcast and popped by a commit monitor in program order.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int DEPTH  = 8;
  localparam int IDX_W  = 3;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reorder_buffer_if #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W)) bus ();

  reorder_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rob    (bus)
  );

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [4:0]        wa;
    logic [DATA_W-1:0] wd;
    logic              we;
    logic              flush;
    logic [DEPTH-1:0]  mask;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   m_tail  = 0;

  always @(negedge clk) begin
    exp_t got;
    exp_t want;
    if (!rst && bus.commit_valid_out) begin
      got = '{idx: bus.commit_rob_idx_out, wa: bus.commit_wa_out, wd: bus.commit_wd_out,
              we: bus.commit_we_out, flush: bus.flush_out, mask: bus.flush_mask_out};
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected: got idx=%0d wa=%0d wd=%h, required no commit",
                 got.idx, got.wa, got.wd);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL commit_tag%0d: got idx=%0d wa=%0d wd=%h we=%b flush=%b mask=%b, required idx=%0d wa=%0d wd=%h we=%b flush=%b mask=%b",
                   want.idx, got.idx, got.wa, got.wd, got.we, got.flush, got.mask,
                   want.idx, want.wa, want.wd, want.we, want.flush, want.mask);
        end
      end
    end else if (!rst && bus.flush_out) begin
      vectors++;
      errors++;
      $display("FAIL flush_alone: got flush_out=1 without commit, required flush only with a retire");
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [4:0] rd);
    vectors++;
    if (bus.alloc_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL alloc_ready rd=%0d: got %b, required 1", rd, bus.alloc_ready_out);
    end
    vectors++;
    if (bus.alloc_idx_out !== IDX_W'(m_tail % DEPTH)) begin
      errors++;
      $display("FAIL alloc_idx rd=%0d: got %0d, required %0d", rd, bus.alloc_idx_out, m_tail % DEPTH);
    end
    bus.alloc_valid_in = 1'b1;
    bus.alloc_rd_in    = rd;
    tick();
    bus.alloc_valid_in = 1'b0;
    m_tail++;
  endtask

  task automatic do_cdb(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] d, input logic mis);
    bus.cdb_valid_in      = 1'b1;
    bus.cdb_rob_idx_in    = idx;
    bus.cdb_data_in       = d;
    bus.cdb_mispredict_in = mis;
    tick();
    bus.cdb_valid_in      = 1'b0;
    bus.cdb_mispredict_in = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d retirements outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.alloc_valid_in = 1'b0;  bus.alloc_rd_in = '0;
    bus.cdb_valid_in   = 1'b0;  bus.cdb_rob_idx_in = '0;
    bus.cdb_data_in    = '0;    bus.cdb_mispredict_in = 1'b0;
    bus.src1_idx_in    = '0;    bus.src2_idx_in = '0;
    exp_q.delete();
    m_tail = 0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.count_out !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d, required 0", bus.count_out); end
    vectors++;
    if (bus.alloc_ready_out !== 1'b1 || bus.alloc_idx_out !== 3'd0) begin
      errors++;
      $display("FAIL reset_alloc: got ready=%b idx=%0d, required ready=1 idx=0", bus.alloc_ready_out, bus.alloc_idx_out);
    end
    vectors++;
    if ({bus.commit_valid_out, bus.commit_we_out, bus.commit_wa_out, bus.commit_wd_out, bus.commit_rob_idx_out} !== '0) begin
      errors++;
      $display("FAIL reset_commit: got valid=%b we=%b wa=%0d wd=%h idx=%0d, required all 0",
               bus.commit_valid_out, bus.commit_we_out, bus.commit_wa_out, bus.commit_wd_out, bus.commit_rob_idx_out);
    end
    vectors++;
    if (bus.flush_out !== 1'b0 || bus.flush_mask_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_flush: got flush=%b mask=%b, required 0/00000000", bus.flush_out, bus.flush_mask_out);
    end
    vectors++;
    if ({bus.src1_ready_out, bus.src2_ready_out, bus.src1_data_out, bus.src2_data_out} !== '0) begin
      errors++;
      $display("FAIL reset_src: got r1=%b r2=%b d1=%h d2=%h, required all 0",
               bus.src1_ready_out, bus.src2_ready_out, bus.src1_data_out, bus.src2_data_out);
    end
  endtask

  task automatic test_fill;
    for (int i = 1; i <= DEPTH; i++) do_alloc(5'(i));
    vectors++;
    if (bus.count_out !== 4'd8 || bus.alloc_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: got count=%0d ready=%b, required count=8 ready=0", bus.count_out, bus.alloc_ready_out);
    end
    bus.alloc_valid_in = 1'b1;
    bus.alloc_rd_in    = 5'd9;
    tick();
    bus.alloc_valid_in = 1'b0;
    vectors++;
    if (bus.count_out !== 4'd8 || bus.alloc_idx_out !== 3'd0) begin
      errors++;
      $display("FAIL fill_reject: got count=%0d idx=%0d, required count=8 idx=0", bus.count_out, bus.alloc_idx_out);
    end
  endtask

  task automatic test_in_order;
    do_cdb(3'd1, 32'h55, 1'b0);
    tick();
    tick();
    vectors++;
    if (bus.count_out !== 4'd8 || bus.commit_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL hold_head: got count=%0d commit=%b, required count=8 commit=0", bus.count_out, bus.commit_valid_out);
    end
    bus.src1_idx_in = 3'd1;
    #1;
    vectors++;
    if (bus.src1_ready_out !== 1'b1 || bus.src1_data_out !== 32'h55) begin
      errors++;
      $display("FAIL src_done: got ready=%b data=%h, required ready=1 data=00000055", bus.src1_ready_out, bus.src1_data_out);
    end
    bus.src1_idx_in = 3'd0;
    exp_q.push_back('{idx: 3'd0, wa: 5'd1, wd: 32'h11, we: 1'b1, flush: 1'b0, mask: 8'h00});
    exp_q.push_back('{idx: 3'd1, wa: 5'd2, wd: 32'h55, we: 1'b1, flush: 1'b0, mask: 8'h00});
    do_cdb(3'd0, 32'h11, 1'b0);
    wait_drain(10);
    vectors++;
    if (bus.count_out !== 4'd6) begin errors++; $display("FAIL count_after_two: got %0d, required 6", bus.count_out); end
    for (int t = 2; t < DEPTH; t++) begin
      exp_q.push_back('{idx: IDX_W'(t), wa: 5'(t + 1), wd: 32'h100 + t, we: 1'b1, flush: 1'b0, mask: 8'h00});
      do_cdb(IDX_W'(t), 32'h100 + t, 1'b0);
    end
    wait_drain(20);
    vectors++;
    if (bus.count_out !== 4'd0) begin errors++; $display("FAIL count_after_drain: got %0d, required 0", bus.count_out); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus.alloc_idx_out !== IDX_W'(i)) begin
        errors++;
        $display("FAIL wrap_tag: got %0d, required %0d", bus.alloc_idx_out, i);
      end
      do_alloc(5'(9 + i));
    end
    vectors++;
    if (bus.count_out !== 4'd3) begin errors++; $display("FAIL wrap_count: got %0d, required 3", bus.count_out); end
    for (int i = 0; i < 3; i++)
      exp_q.push_back('{idx: IDX_W'(i), wa: 5'(9 + i), wd: 32'h200 + i, we: 1'b1, flush: 1'b0, mask: 8'h00});
    for (int i = 2; i >= 0; i--) do_cdb(IDX_W'(i), 32'h200 + i, 1'b0);
    wait_drain(10);
  endtask

  task automatic test_x0;
    logic [IDX_W-1:0] t;
    t = IDX_W'(m_tail % DEPTH);
    do_alloc(5'd0);
    exp_q.push_back('{idx: t, wa: 5'd0, wd: 32'hFF, we: 1'b0, flush: 1'b0, mask: 8'h00});
    do_cdb(t, 32'hFF, 1'b0);
    wait_drain(10);
  endtask

  task automatic test_forward;
    logic [IDX_W-1:0] t;
    t = IDX_W'(m_tail % DEPTH);
    do_alloc(5'd5);
    bus.src1_idx_in = t;
    bus.src2_idx_in = t + 3'd1;
    #1;
    vectors++;
    if (bus.src1_ready_out !== 1'b0 || bus.src2_ready_out !== 1'b0 || bus.src2_data_out !== 32'h0) begin
      errors++;
      $display("FAIL src_pending: got r1=%b r2=%b d2=%h, required r1=0 r2=0 d2=0",
               bus.src1_ready_out, bus.src2_ready_out, bus.src2_data_out);
    end
    bus.cdb_valid_in   = 1'b1;
    bus.cdb_rob_idx_in = t;
    bus.cdb_data_in    = 32'hABCD;
    #1;
    vectors++;
    if (bus.src1_ready_out !== 1'b1 || bus.src1_data_out !== 32'hABCD) begin
      errors++;
      $display("FAIL src_bypass: got ready=%b data=%h, required ready=1 data=0000abcd", bus.src1_ready_out, bus.src1_data_out);
    end
    exp_q.push_back('{idx: t, wa: 5'd5, wd: 32'hABCD, we: 1'b1, flush: 1'b0, mask: 8'h00});
    tick();
    bus.cdb_valid_in = 1'b0;
    #1;
    vectors++;
    if (bus.src1_ready_out !== 1'b1 || bus.src1_data_out !== 32'hABCD) begin
      errors++;
      $display("FAIL src_stored: got ready=%b data=%h, required ready=1 data=0000abcd", bus.src1_ready_out, bus.src1_data_out);
    end
    wait_drain(10);
    bus.src1_idx_in = '0;
    bus.src2_idx_in = '0;
  endtask

  task automatic test_mispredict;
    bit seen;
    test_reset();
    for (int i = 1; i <= 4; i++) do_alloc(5'(i));
    exp_q.push_back('{idx: 3'd0, wa: 5'd1, wd: 32'h10, we: 1'b1, flush: 1'b0, mask: 8'h00});
    exp_q.push_back('{idx: 3'd1, wa: 5'd2, wd: 32'h22, we: 1'b1, flush: 1'b1, mask: 8'b0000_1100});
    do_cdb(3'd1, 32'h22, 1'b1);
    do_cdb(3'd0, 32'h10, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = bus.flush_out;
    end
    vectors++;
    if (!seen) begin
      errors++;
      $display("FAIL flush_timeout: got no flush_out, required flush within 10 cycles");
    end else begin
      vectors++;
      if (bus.count_out !== 4'd0 || bus.alloc_ready_out !== 1'b0 || bus.flush_mask_out !== 8'b0000_1100) begin
        errors++;
        $display("FAIL flush_cycle: got count=%0d ready=%b mask=%b, required count=0 ready=0 mask=00001100",
                 bus.count_out, bus.alloc_ready_out, bus.flush_mask_out);
      end
      bus.alloc_valid_in = 1'b1;
      bus.alloc_rd_in    = 5'd7;
      tick();
      bus.alloc_valid_in = 1'b0;
      vectors++;
      if (bus.count_out !== 4'd0 || bus.flush_out !== 1'b0 || bus.alloc_idx_out !== 3'd4) begin
        errors++;
        $display("FAIL after_flush: got count=%0d flush=%b idx=%0d, required count=0 flush=0 idx=4",
                 bus.count_out, bus.flush_out, bus.alloc_idx_out);
      end
      do_alloc(5'd7);
    end
    wait_drain(5);
  endtask

  task automatic test_reset_mid;
    logic [IDX_W-1:0] t;
    t = IDX_W'(m_tail % DEPTH);
    do_alloc(5'd3);
    do_alloc(5'd4);
    do_cdb(t + 3'd1, 32'h77, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.count_out !== 4'd0 || bus.alloc_ready_out !== 1'b1 || bus.alloc_idx_out !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: got count=%0d ready=%b idx=%0d, required count=0 ready=1 idx=0",
               bus.count_out, bus.alloc_ready_out, bus.alloc_idx_out);
    end
    exp_q.delete();
    m_tail = 0;
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.commit_valid_out !== 1'b0 || bus.src2_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got commit=%b src2_ready=%b, required 0/0", bus.commit_valid_out, bus.src2_ready_out);
    end
    do_alloc(5'd3);
    exp_q.push_back('{idx: 3'd0, wa: 5'd3, wd: 32'h33, we: 1'b1, flush: 1'b0, mask: 8'h00});
    do_cdb(3'd0, 32'h33, 1'b0);
    wait_drain(10);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_in_order();
    test_wrap();
    test_x0();
    test_forward();
    test_mispredict();
    test_reset_mid();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
